parallel_collector: RTL and testbench
=====================================

PARALLEL_COLLECTOR -- requirements
Module: parallel_collector

Interface
REQ-001 SHALL have parameter N, default 2: systolic array dimension (NxN result matrix).
REQ-002 SHALL have parameter W, default 16: width of each result element in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port C_serial, input, N x W bits: per-row result element, one stream per array row.
REQ-006 SHALL have port row_valid, input, N bits: bit r qualifies C_serial[r] this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: high when the block accepts row data.
REQ-008 SHALL have port C, output, N x N x W bits: assembled result matrix, C[r][c].
REQ-009 SHALL have port out_valid, output, 1 bit: matrix in C complete and stable.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts C.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, element dropped on a completed row.

Function
REQ-012 SHALL implement states COLLECT and DONE; reset state COLLECT.
REQ-013 SHALL keep one column counter per row, range 0..N, all 0 after reset.
REQ-014 In COLLECT, row_valid[r] with counter[r] < N SHALL write C_serial[r] into C[r][counter[r]] and increment counter[r] on the same edge.
REQ-015 Rows SHALL be independent: skewed arrival (row r starting r cycles late) SHALL assemble correctly.
REQ-016 row_valid[r] with counter[r] == N in COLLECT SHALL be dropped, leave C unchanged, and set overrun.
REQ-017 The edge on which the last counter reaches N SHALL move the state to DONE; out_valid SHALL be high the following cycle (latency 1 cycle from last element).
REQ-018 in_ready SHALL be high in COLLECT and low in DONE; row_valid in DONE SHALL be ignored, without setting overrun.
REQ-019 In DONE, C SHALL hold and out_valid SHALL stay high until out_valid && out_ready.
REQ-020 On handshake, SHALL return to COLLECT, clear all counters, and drop out_valid next cycle; C SHALL retain old values until overwritten.
REQ-021 row_valid coinciding with the handshake cycle SHALL be ignored; the first new element is accepted the cycle after.
REQ-022 out_ready while out_valid is low SHALL have no effect.
REQ-023 overrun SHALL clear only on reset.

Reset
REQ-024 Asserting rst low SHALL asynchronously force: state COLLECT, all counters 0, all C elements 0, out_valid 0, overrun 0, in_ready 1.
REQ-025 Reset mid-collection or in DONE SHALL discard partial or unread data; no handshake is required.
REQ-026 The first edge after rst deasserts SHALL accept row_valid normally.

Configuration
REQ-027 Macro PARALLEL_COLLECTOR_SAT_EN defined: each captured element SHALL be treated as signed W-bit, clamped to [-128, 127], and stored sign-extended to W bits.
REQ-028 Macro PARALLEL_COLLECTOR_SAT_EN undefined: elements SHALL be stored unmodified; no clamp logic present.

Verification
REQ-029 N=2: row_valid=2'b11 for 2 cycles, C_serial rows {1,3},{2,4} -> C=[[1,2],[3,4]], out_valid high 1 cycle after 2nd beat.
REQ-030 N=2 skewed: row0 valid cycles 0-1 (5,6), row1 valid cycles 1-2 (7,8) -> C=[[5,6],[7,8]], out_valid rises after cycle 2 edge.
REQ-031 Row0 complete, row1 has 1 element, extra row0 beat 9 -> overrun=1, C[0] unchanged, still COLLECT.
REQ-032 DONE with out_ready low 5 cycles then high; row_valid=2'b11 throughout -> C stable, in_ready 0, overrun 0, out_valid drops after handshake, next matrix fills from column 0.
REQ-033 rst low mid-collection after 1 beat -> C all 0, out_valid 0, counters 0; fresh 2-beat matrix then completes normally.
REQ-034 SAT_EN defined, W=16, input 300 and -200 -> stored 127 and -128; undefined -> stored 300 and -200.

Source files
------------

// File: rtl/parallel_collector_if.sv
// parallel_collector_if: row-stream input and matrix-output handshake bundle for parallel_collector.
interface parallel_collector_if #(parameter int N = 2, parameter int W = 16);
    logic [N-1:0][W-1:0]        C_serial;
    logic [N-1:0]               row_valid;
    logic                       in_ready;
    logic [N-1:0][N-1:0][W-1:0] C;
    logic                       out_valid;
    logic                       out_ready;
    logic                       overrun;
    modport master (output C_serial, row_valid, out_ready, input in_ready, C, out_valid, overrun);
    modport slave (input C_serial, row_valid, out_ready, output in_ready, C, out_valid, overrun);
endinterface

// File: rtl/parallel_collector.sv
// parallel_collector: assembles N per-row result streams into an NxN matrix with a valid/ready output.
// Define PARALLEL_COLLECTOR_SAT_EN to clamp each captured element to signed [-128, 127].
module parallel_collector #(
    parameter int N = 2,
    parameter int W = 16
) (
    input logic clk,
    input logic rst,
    parallel_collector_if.slave b
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic {COLLECT, DONE} state_t;
    state_t state, state_nx;
    logic [N-1:0][CW-1:0] cnt, cnt_nx;
    logic [N-1:0][N-1:0][W-1:0] c_q, c_nx;
    logic ovr, ovr_nx, all_full;
`ifdef PARALLEL_COLLECTOR_SAT_EN
    localparam logic signed [W-1:0] hi = W'(127);
    localparam logic signed [W-1:0] lo = W'(-128);
    function automatic logic [W-1:0] sat(input logic [W-1:0] x);
        return $signed(x) > hi ? hi : ($signed(x) < lo ? lo : x);
    endfunction
`else
    function automatic logic [W-1:0] sat(input logic [W-1:0] x);
        return x;
    endfunction
`endif
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        c_nx = c_q;
        ovr_nx = ovr;
        all_full = 1'b1;
        for (int r = 0; r < N; r++) begin
            if (state == COLLECT && b.row_valid[r]) begin
                if (cnt[r] == CW'(N)) ovr_nx = 1'b1;
                else begin
                    for (int c = 0; c < N; c++)
                        if (cnt[r] == CW'(c)) c_nx[r][c] = sat(b.C_serial[r]);
                    cnt_nx[r] = cnt[r] + CW'(1);
                end
            end
            all_full &= cnt_nx[r] == CW'(N);
        end
        if (state == COLLECT && all_full) state_nx = DONE;
        // Handshake clears counters but C keeps its contents until overwritten
        if (state == DONE && b.out_ready) begin
            state_nx = COLLECT;
            cnt_nx = '0;
        end
        b.in_ready = state == COLLECT;
        b.out_valid = state == DONE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
            cnt <= '0;
            c_q <= '0;
            ovr <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            c_q <= c_nx;
            ovr <= ovr_nx;
        end
    end
    assign b.C = c_q;
    assign b.overrun = ovr;
endmodule

// File: tb/tb_parallel_collector.sv
// tb_parallel_collector: directed and random stimulus against a queue-based matrix model.
module tb_parallel_collector;
    localparam int N = 2;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    parallel_collector_if #(.N(N), .W(W)) bus ();
    parallel_collector #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .b(bus));
    int errs = 0;
    int checks = 0;
    logic [W-1:0] ex [N][N];
    logic [W-1:0] rowq [N][$];
    bit done = 0;
    bit ovr = 0;

    function automatic logic [W-1:0] sat(logic [W-1:0] x);
`ifdef PARALLEL_COLLECTOR_SAT_EN
        int v;
        v = int'($signed(x));
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return W'(v);
`else
        return x;
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exv);
        checks++;
        assert (obs === exv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exv);
        end
    endtask

    task automatic check_all(string tag);
        logic [N-1:0][N-1:0][W-1:0] e;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) e[r][c] = ex[r][c];
        chk({tag, ".C"}, bus.C, e);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(done));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(!done));
        chk({tag, ".overrun"}, 64'(bus.overrun), 64'(ovr));
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++) begin
            rowq[r].delete();
            for (int c = 0; c < N; c++) ex[r][c] = '0;
        end
        done = 0;
        ovr = 0;
    endtask

    task automatic step(string tag, logic [N-1:0] v, logic [W-1:0] d0, logic [W-1:0] d1, logic ordy);
        logic [W-1:0] d [N];
        d[0] = d0;
        d[1] = d1;
        bus.row_valid = v;
        bus.C_serial[0] = d0;
        bus.C_serial[1] = d1;
        bus.out_ready = ordy;
        if (!done) begin
            for (int r = 0; r < N; r++)
                if (v[r]) begin
                    if (rowq[r].size() < N) begin
                        ex[r][rowq[r].size()] = sat(d[r]);
                        rowq[r].push_back(sat(d[r]));
                    end else ovr = 1;
                end
            done = 1;
            for (int r = 0; r < N; r++) if (rowq[r].size() != N) done = 0;
        end else if (ordy) begin
            done = 0;
            for (int r = 0; r < N; r++) rowq[r].delete();
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.row_valid = '0;
        bus.C_serial = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #7;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Aligned rows
        step("basic1", 2'b11, 16'd1, 16'd3, 1'b0);
        step("basic2", 2'b11, 16'd2, 16'd4, 1'b0);
        step("basic_hs", 2'b00, 16'd0, 16'd0, 1'b1);
        step("idle_ordy", 2'b00, 16'd0, 16'd0, 1'b1);
        // Skewed rows
        step("skew1", 2'b01, 16'd5, 16'd0, 1'b0);
        step("skew2", 2'b11, 16'd6, 16'd7, 1'b0);
        step("skew3", 2'b10, 16'd0, 16'd8, 1'b0);
        // DONE holds with row_valid asserted, then handshake, then refill from column 0
        for (int i = 0; i < 5; i++) step("hold", 2'b11, 16'd99, 16'd98, 1'b0);
        step("hold_hs", 2'b11, 16'd77, 16'd76, 1'b1);
        step("refill1", 2'b11, 16'd10, 16'd30, 1'b0);
        step("refill2", 2'b11, 16'd20, 16'd40, 1'b0);
        step("refill_hs", 2'b00, 16'd0, 16'd0, 1'b1);
        // Overrun on a completed row
        step("ovr1", 2'b11, 16'd1, 16'd2, 1'b0);
        step("ovr2", 2'b01, 16'd3, 16'd0, 1'b0);
        step("ovr3", 2'b01, 16'd9, 16'd0, 1'b0);
        step("ovr4", 2'b10, 16'd0, 16'd4, 1'b0);
        step("ovr_hs", 2'b00, 16'd0, 16'd0, 1'b1);
        // Reset mid-collection, then a fresh matrix
        step("mid1", 2'b11, 16'd11, 16'd12, 1'b0);
        do_reset("mid_rst");
        step("fresh1", 2'b11, 16'd13, 16'd15, 1'b0);
        step("fresh2", 2'b11, 16'd14, 16'd16, 1'b0);
        step("fresh_hs", 2'b00, 16'd0, 16'd0, 1'b1);
        // Saturation boundary values
        step("sat1", 2'b11, 16'd300, 16'(-200), 1'b0);
        step("sat2", 2'b11, 16'(-129), 16'd127, 1'b0);
`ifdef PARALLEL_COLLECTOR_SAT_EN
        chk("sat_hi", 64'(bus.C[0][0]), 64'(16'd127));
        chk("sat_lo", 64'(bus.C[1][0]), 64'(16'hFF80));
`else
        chk("raw_hi", 64'(bus.C[0][0]), 64'(16'd300));
        chk("raw_lo", 64'(bus.C[1][0]), 64'(16'hFF38));
`endif
        step("sat_hs", 2'b00, 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            else step("rnd", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
